// File: rtl/run_extractor.sv
// Raster-to-run-length front end: turns a binary pixel stream into per-row run entries
// (start, end, row, eor, empty, eof) queued in a first-word-fall-through FIFO.
module run_extractor #(
   parameter int unsigned img_w     = 640,
   parameter int unsigned img_h     = 480,
   parameter int unsigned col_bit   = 10,
   parameter int unsigned row_bit   = 9,
   parameter int unsigned fifo_abit = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               datavalid,
   input  logic               sof,
   input  logic               pix,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [col_bit-1:0] out_start,
   output logic [col_bit-1:0] out_end,
   output logic [row_bit-1:0] out_row,
   output logic               out_eor,
   output logic               out_empty,
   output logic               out_eof,
   output logic               ovf
);

   localparam int unsigned ent_w = 2 * col_bit + row_bit + 3;
   localparam int unsigned depth = 2 ** fifo_abit;
   localparam int unsigned cnt_w = fifo_abit + 1;
   localparam logic [col_bit-1:0] last_col = col_bit'(img_w - 1);
   localparam logic [row_bit-1:0] last_row = row_bit'(img_h - 1);

   typedef enum logic {IDLE, INRUN} state_t;

   state_t             state_q, state_d;
   logic [col_bit-1:0] x_q, x_d, start_q, start_d, cur_x;
   logic [row_bit-1:0] y_q, y_d, cur_y;
   logic               eff_run;

   logic               push;
   logic [ent_w-1:0]   push_data;
   logic [col_bit-1:0] e_start, e_end;
   logic               e_eor, e_empty, e_eof;

   logic [ent_w-1:0]     mem [depth];
   logic [fifo_abit-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [cnt_w-1:0]     cnt_q, cnt_d;
   logic [ent_w-1:0]     head_q, head_d;
   logic                 valid_q, valid_d, ovf_q, ovf_d;
   logic                 pop, full, push_ok;

   // Run FSM and pixel position; a sof pixel is forced to (0,0) and abandons any open run
   always_comb begin
      state_d   = state_q;
      start_d   = start_q;
      x_d       = x_q;
      y_d       = y_q;
      push      = 1'b0;
      e_start   = '0;
      e_end     = '0;
      e_eor     = 1'b0;
      e_empty   = 1'b0;
      e_eof     = 1'b0;
      cur_x     = sof ? '0 : x_q;
      cur_y     = sof ? '0 : y_q;
      eff_run   = (state_q == INRUN) && !sof;

      if (datavalid) begin
         if (cur_x == last_col) begin
            // Last column always closes the row with exactly one entry
            x_d     = '0;
            y_d     = (cur_y == last_row) ? '0 : cur_y + 1'b1;
            state_d = IDLE;
            push    = 1'b1;
            e_eor   = 1'b1;
            e_eof   = (cur_y == last_row);
            if (pix) begin
               e_start = eff_run ? start_q : cur_x;
               e_end   = cur_x;
            end else if (eff_run) begin
               e_start = start_q;
               e_end   = cur_x - 1'b1;
            end else begin
               e_empty = 1'b1;
            end
         end else begin
            x_d = cur_x + 1'b1;
            y_d = cur_y;
            if (!eff_run) begin
               if (pix) begin
                  start_d = cur_x;
                  state_d = INRUN;
               end else begin
                  state_d = IDLE;
               end
            end else if (!pix) begin
               push    = 1'b1;
               e_start = start_q;
               e_end   = cur_x - 1'b1;
               state_d = IDLE;
            end
         end
      end
      push_data = {e_start, e_end, cur_y, e_eor, e_empty, e_eof};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         start_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   // FIFO control; the head is re-registered so the write-through case needs the incoming entry
   always_comb begin
      pop     = valid_q && out_ready;
      full    = (cnt_q == cnt_w'(depth));
      push_ok = push && (!full || pop);
      wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
      rd_d    = pop ? rd_q + 1'b1 : rd_q;
      cnt_d   = cnt_q;
      if (push_ok && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!push_ok && pop) begin
         cnt_d = cnt_q - 1'b1;
      end
      head_d = '0;
      if (cnt_d != '0) begin
         head_d = (push_ok && (rd_d == wr_q)) ? push_data : mem[rd_d];
      end
      valid_d = (cnt_d != '0);
      ovf_d   = ovf_q;
      if (datavalid && sof) begin
         ovf_d = 1'b0;
      end else if (push && full && !pop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         head_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_q] <= push_data;
      end
   end

   assign out_valid = valid_q;
   assign ovf       = ovf_q;
   assign {out_start, out_end, out_row, out_eor, out_empty, out_eof} = head_q;

endmodule

// File: tb/tb_run_extractor.sv
// Directed vector bench for run_extractor with a small frame (8x2) and a 4-deep FIFO.
module tb_run_extractor;

   localparam int unsigned W  = 8;
   localparam int unsigned H  = 2;
   localparam int unsigned CB = 3;
   localparam int unsigned RB = 1;
   localparam int unsigned FA = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          datavalid = 1'b0;
   logic          sof = 1'b0;
   logic          pix = 1'b0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [CB-1:0] out_start, out_end;
   logic [RB-1:0] out_row;
   logic          out_eor, out_empty, out_eof, ovf;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic dv, sf, px, rdy;
      logic ev;
      int   es, ee, er, eor, emp, eof, eovf;
   } vec_t;

   vec_t vecs[$];
   int   split;

   run_extractor #(.img_w(W), .img_h(H), .col_bit(CB), .row_bit(RB), .fifo_abit(FA)) dut (
      .clk(clk), .rst(rst), .datavalid(datavalid), .sof(sof), .pix(pix),
      .out_valid(out_valid), .out_ready(out_ready), .out_start(out_start), .out_end(out_end),
      .out_row(out_row), .out_eor(out_eor), .out_empty(out_empty), .out_eof(out_eof), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d got=%0d exp=%0d", name, idx, act, exp);
      end
   endtask

   // Vector with no entry expected at the head
   task automatic vn(input logic dv, input logic sf, input logic px, input logic rdy, input int eovf);
      vec_t v;
      v = '{dv:dv, sf:sf, px:px, rdy:rdy, ev:1'b0, es:0, ee:0, er:0, eor:0, emp:0, eof:0, eovf:eovf};
      vecs.push_back(v);
   endtask

   // Vector with a specific head entry expected
   task automatic ve(input logic dv, input logic sf, input logic px, input logic rdy,
                     input int es, input int ee, input int er, input int eor,
                     input int emp, input int eof, input int eovf);
      vec_t v;
      v = '{dv:dv, sf:sf, px:px, rdy:rdy, ev:1'b1, es:es, ee:ee, er:er, eor:eor, emp:emp, eof:eof, eovf:eovf};
      vecs.push_back(v);
   endtask

   task automatic apply(input vec_t v, input int idx);
      datavalid = v.dv;
      sof       = v.sf;
      pix       = v.px;
      out_ready = v.rdy;
      @(posedge clk);
      #1;
      chk("valid", idx, 32'(out_valid), 32'(v.ev));
      if (v.ev) begin
         chk("start", idx, 32'(out_start), v.es);
         chk("end",   idx, 32'(out_end),   v.ee);
         chk("row",   idx, 32'(out_row),   v.er);
         chk("eor",   idx, 32'(out_eor),   v.eor);
         chk("empty", idx, 32'(out_empty), v.emp);
         chk("eof",   idx, 32'(out_eof),   v.eof);
      end
      chk("ovf", idx, 32'(ovf), v.eovf);
      @(negedge clk);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valid"}, -1, 32'(out_valid), 0);
      chk({tag, "_ovf"},   -1, 32'(ovf),       0);
      chk({tag, "_start"}, -1, 32'(out_start), 0);
      chk({tag, "_end"},   -1, 32'(out_end),   0);
      chk({tag, "_row"},   -1, 32'(out_row),   0);
      chk({tag, "_flags"}, -1, {29'd0, out_eor, out_empty, out_eof}, 0);
   endtask

   initial begin
      // sof then 0,1,1,0,0,0,1,1 with a datavalid gap inside the first run
      vn(1,1,0,1,0);
      vn(1,0,1,1,0);
      vn(0,0,0,1,0);
      vn(1,0,1,1,0);
      ve(1,0,0,1, 1,2,0,0,0,0, 0);
      vn(1,0,0,1,0);
      vn(1,0,0,1,0);
      vn(1,0,1,1,0);
      ve(1,0,1,1, 6,7,0,1,0,0, 0);
      // row 1 all zeros: one empty marker closing the frame
      for (int i = 0; i < 7; i++) vn(1,0,0,1,0);
      ve(1,0,0,1, 0,0,1,1,1,1, 0);
      // no sof: wraps to (0,0); 1,0,1,0,1,0,1,1 with ready low fills the FIFO
      vn(1,0,1,1,0);
      ve(1,0,0,0, 0,0,0,0,0,0, 0);
      ve(1,0,1,0, 0,0,0,0,0,0, 0);
      ve(1,0,0,0, 0,0,0,0,0,0, 0);
      ve(1,0,1,0, 0,0,0,0,0,0, 0);
      ve(1,0,0,0, 0,0,0,0,0,0, 0);
      ve(1,0,1,0, 0,0,0,0,0,0, 0);
      ve(1,0,1,0, 0,0,0,0,0,0, 0);
      // row 1: first run dropped while full, then drain in order
      ve(1,0,1,0, 0,0,0,0,0,0, 0);
      ve(1,0,0,0, 0,0,0,0,0,0, 1);
      ve(1,0,0,1, 2,2,0,0,0,0, 1);
      ve(1,0,0,1, 4,4,0,0,0,0, 1);
      ve(1,0,0,1, 6,7,0,1,0,0, 1);
      vn(1,0,0,1,1);
      vn(1,0,0,1,1);
      ve(1,0,0,1, 0,0,1,1,1,1, 1);
      // open run 1..2 abandoned by sof; sof pixel starts a run; ovf cleared
      vn(1,0,0,1,1);
      vn(1,0,1,1,1);
      vn(1,0,1,1,1);
      vn(1,1,1,1,0);
      ve(1,0,0,1, 0,0,0,0,0,0, 0);
      // fill to 4, then a push coinciding with a pop while full
      ve(1,0,1,0, 0,0,0,0,0,0, 0);
      ve(1,0,0,0, 0,0,0,0,0,0, 0);
      ve(1,0,1,0, 0,0,0,0,0,0, 0);
      ve(1,0,0,0, 0,0,0,0,0,0, 0);
      ve(1,0,1,0, 0,0,0,0,0,0, 0);
      ve(1,0,1,0, 0,0,0,0,0,0, 0);
      ve(1,0,1,0, 0,0,0,0,0,0, 0);
      ve(1,0,0,1, 2,2,0,0,0,0, 0);
      ve(1,0,0,1, 4,4,0,0,0,0, 0);
      ve(1,0,0,1, 6,7,0,1,0,0, 0);
      ve(1,0,0,1, 0,0,1,0,0,0, 0);
      vn(1,0,0,1,0);
      vn(1,0,0,1,0);
      ve(1,0,0,1, 0,0,1,1,1,1, 0);
      vn(0,0,0,1,0);
      // queue three entries and leave a run open before reset
      vn(1,1,1,0,0);
      ve(1,0,0,0, 0,0,0,0,0,0, 0);
      ve(1,0,1,0, 0,0,0,0,0,0, 0);
      ve(1,0,0,0, 0,0,0,0,0,0, 0);
      ve(1,0,1,0, 0,0,0,0,0,0, 0);
      ve(1,0,0,0, 0,0,0,0,0,0, 0);
      ve(1,0,1,0, 0,0,0,0,0,0, 0);
      split = vecs.size();
      // after reset: sof row 0,0,0,0,0,0,0,1 gives only (7,7)
      vn(1,1,0,1,0);
      for (int i = 0; i < 6; i++) vn(1,0,0,1,0);
      ve(1,0,1,1, 7,7,0,1,0,0, 0);
      vn(0,0,0,1,0);
      vn(0,0,0,1,0);

      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < split; i++) apply(vecs[i], i);

      // asynchronous reset mid-run with entries queued
      datavalid = 1'b0;
      sof       = 1'b0;
      pix       = 1'b0;
      rst       = 1'b0;
      #1;
      chk_idle_outputs("async_rst");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = split; i < vecs.size(); i++) apply(vecs[i], i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
